// File: rtl/demux_frame_sequencer_pkg.sv
// demux_pkg: shared widths and sequencer state encoding for the demux frame driver
package demux_pkg;
  localparam int SEL_W = 3;
  localparam int NUM_CH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
endpackage

// File: rtl/demux_frame_sequencer_if.sv
// demux_frame_sequencer_if: valid/ready frame request channel {dest, payload}
interface demux_frame_sequencer_if #(parameter int W = 8);
  import demux_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [SEL_W-1:0] in_dest;
  logic [W-1:0] in_data;
  modport master (output in_valid, in_dest, in_data, input in_ready);
  modport slave (input in_valid, in_dest, in_data, output in_ready);
endinterface

// File: rtl/demux_frame_sequencer_piso_shreg.sv
// piso_shreg: parallel load, LSB-first shift, registered serial out that idles low
module piso_shreg #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data,
  output logic         q
);
  logic [W-1:0] sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      q <= 1'b0;
    end else begin
      q <= load ? data[0] : shift ? sh[0] : 1'b0;
      sh <= load ? data >> 1 : shift ? sh >> 1 : sh;
    end
endmodule

// File: rtl/demux_frame_sequencer.sv
// demux_frame_sequencer: holds S=dest and serialises the payload LSB-first onto D,
// forcing D low between frames so every demux output idles low.
module demux_frame_sequencer #(
  parameter int W = 8,
  parameter int GAP = 1
) (
  input  logic clk,
  input  logic rst_n,
  demux_frame_sequencer_if.slave bus,
  output logic [2:0] S,
  output logic D,
  output logic busy,
  output logic done
);
  import demux_pkg::*;
  localparam int CW = $clog2(W + 1);
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic hs, last, shift;
  assign hs = bus.in_valid & bus.in_ready;
  assign last = state == SHIFT && cnt == '0;
  assign shift = state == SHIFT && cnt != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // the enum member GAP is qualified because the parameter GAP shadows it here
  always_comb
    nxt = (state == IDLE && bus.in_valid) ? SHIFT :
          last ? (GAP > 0 ? demux_pkg::GAP : IDLE) :
          (state == demux_pkg::GAP && gcnt == '0) ? IDLE : state;
  always_comb begin
    bus.in_ready = state == IDLE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      S <= '0;
      cnt <= '0;
      gcnt <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      S <= hs ? bus.in_dest : S;
      cnt <= hs ? CW'(W - 1) : shift ? cnt - 1'b1 : cnt;
      gcnt <= last ? GW'(GAP > 0 ? GAP - 1 : 0) :
              state == demux_pkg::GAP ? gcnt - 1'b1 : gcnt;
    end
  piso_shreg #(.W(W)) u_piso (
    .clk(clk),
    .rst_n(rst_n),
    .load(hs),
    .shift(shift),
    .data(bus.in_data),
    .q(D)
  );
endmodule

// File: tb/tb_demux_frame_sequencer.sv
// tb_demux_frame_sequencer: W=8/GAP=1 and W=1/GAP=0 instances checked against a
// timing model where cycle k+i of a frame accepted at edge k shows payload bit i.
module tb_demux_frame_sequencer;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  demux_frame_sequencer_if #(.W(8)) ia ();
  demux_frame_sequencer_if #(.W(1)) ib ();
  logic [2:0] sa, sb;
  logic da, db, ba, bb, doa, dob;
  demux_frame_sequencer #(.W(8), .GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .S(sa), .D(da), .busy(ba), .done(doa));
  demux_frame_sequencer #(.W(1), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .S(sb), .D(db), .busy(bb), .done(dob));
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int k[2];
  bit act[2];
  logic [7:0] md[2];
  logic [2:0] ms[2];
  function automatic int wj(int j);
    return j == 0 ? 8 : 1;
  endfunction
  function automatic int gj(int j);
    return j == 0 ? 1 : 0;
  endfunction
  function automatic bit mrdy(int j);
    return !act[j] || (cyc - k[j] >= wj(j) + gj(j));
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc <= 0;
      for (int j = 0; j < 2; j++) begin
        act[j] <= 1'b0;
        ms[j] <= '0;
      end
    end else begin
      cyc <= cyc + 1;
      if (ia.in_valid && mrdy(0)) begin
        act[0] <= 1'b1; k[0] <= cyc + 1; md[0] <= ia.in_data; ms[0] <= ia.in_dest;
      end
      if (ib.in_valid && mrdy(1)) begin
        act[1] <= 1'b1; k[1] <= cyc + 1; md[1] <= {7'b0, ib.in_data}; ms[1] <= ib.in_dest;
      end
    end
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, req, cyc);
    end
  endtask
  task automatic check_j(int j, logic d, logic [2:0] s, logic b, logic dn, logic r);
    int i;
    logic ed, er, edn;
    logic [7:0] y, ey;
    i = cyc - k[j];
    ed = (act[j] && i < wj(j)) ? md[j][i] : 1'b0;
    er = !act[j] || i >= wj(j) + gj(j);
    edn = act[j] && i == wj(j);
    y = 8'(d) << s;
    ey = 8'(ed) << ms[j];
    chk($sformatf("D%0d", j), 8'(d), 8'(ed));
    chk($sformatf("S%0d", j), 8'(s), 8'(ms[j]));
    chk($sformatf("busy%0d", j), 8'(b), 8'(!er));
    chk($sformatf("done%0d", j), 8'(dn), 8'(edn));
    chk($sformatf("ready%0d", j), 8'(r), 8'(er));
    chk($sformatf("Y%0d", j), y, ey);
  endtask
  task automatic check_all();
    check_j(0, da, sa, ba, doa, ia.in_ready);
    check_j(1, db, sb, bb, dob, ib.in_ready);
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask
  task automatic offer(int j, logic [2:0] dest, logic [7:0] data);
    bit got;
    got = 0;
    if (j == 0) begin
      ia.in_valid = 1; ia.in_dest = dest; ia.in_data = data;
    end else begin
      ib.in_valid = 1; ib.in_dest = dest; ib.in_data = data[0];
    end
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      got = act[j] && k[j] == cyc;
    end
    chk($sformatf("handshake%0d", j), 8'(got), 8'd1);
  endtask
  logic [7:0] seq;
  initial begin
    ia.in_valid = 0; ia.in_dest = 0; ia.in_data = 0;
    ib.in_valid = 0; ib.in_dest = 0; ib.in_data = 0;
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1;
    tick();
    // single frame, explicit bit order and completion timing
    offer(0, 3'd3, 8'b1011_0010);
    ia.in_valid = 0;
    seq[0] = da;
    for (int i = 1; i < 8; i++) begin
      tick();
      seq[i] = da;
    end
    chk("seq", seq, 8'b1011_0010);
    tick();
    chk("done_k8", 8'(doa), 8'd1);
    tick();
    chk("ready_k9", 8'(ia.in_ready), 8'd1);
    // back-to-back with valid held
    offer(0, 3'd5, 8'($urandom));
    offer(0, 3'd6, 8'($urandom));
    ia.in_valid = 0;
    repeat (10) tick();
    // W=1, GAP=0
    offer(1, 3'd7, 8'h01);
    ib.in_valid = 0;
    chk("y7_on", 8'(8'(db) << sb), 8'h80);
    tick();
    chk("done_w1", 8'(dob), 8'd1);
    chk("rdy_w1", 8'(ib.in_ready), 8'd1);
    tick();
    // reset mid-frame
    offer(0, 3'd2, 8'hFF);
    ia.in_valid = 0;
    tick();
    tick();
    #2 rst_n = 0;
    #1 check_all();
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("no_done", 8'(doa), 8'd0);
    offer(0, 3'd2, 8'hA5);
    ia.in_valid = 0;
    repeat (10) tick();
    // ignored request while busy
    offer(0, 3'd4, 8'h3C);
    ia.in_valid = 0;
    tick();
    tick();
    ia.in_valid = 1; ia.in_dest = 3'd1; ia.in_data = 8'hFF;
    tick();
    ia.in_valid = 0;
    chk("S_hold", 8'(sa), 8'd4);
    repeat (10) tick();
    // random traffic on both channels
    repeat (300) begin
      if (!ia.in_valid && $urandom_range(2) == 0) begin
        ia.in_valid = 1; ia.in_dest = 3'($urandom); ia.in_data = 8'($urandom);
      end
      if (!ib.in_valid && $urandom_range(2) == 0) begin
        ib.in_valid = 1; ib.in_dest = 3'($urandom); ib.in_data = 1'($urandom);
      end
      tick();
      if (act[0] && k[0] == cyc) ia.in_valid = 0;
      if (act[1] && k[1] == cyc) ib.in_valid = 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
